mdom_waveform_buffer: RTL and testbench



---
 rtl/mdom_waveform_buffer.sv | 183 ++++++++++++++++++
 tb/tb_mdom_waveform_buffer.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdom_waveform_buffer.sv
// Single-channel mDOM waveform buffer: pretrigger delay line feeding a 4096x22
// circular sample memory, plus a 512x80 header FIFO and sticky overflow.
module mdom_waveform_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] ltc_in,
  input  logic [11:0] adc_in,
  input  logic [7:0]  discr_in,
  input  logic        tot,
  input  logic        trig,
  input  logic [1:0]  trig_src,
  input  logic        arm,
  input  logic        wvb_rdreq,
  input  logic        hdr_rdreq,
  input  logic        wvb_rddone,
  input  logic [4:0]  pre_conf,
  input  logic [11:0] post_conf,
  input  logic [11:0] test_conf,
  input  logic        cnst_run,
  input  logic [11:0] cnst_conf,
  input  logic        trig_mode,
  output logic [21:0] wvb_data_out,
  output logic [11:0] wvb_wused,
  output logic [9:0]  n_wvf_in_buf,
  output logic        wvb_overflow,
  output logic        armed,
  output logic [79:0] hdr_data_out,
  output logic        hdr_full,
  output logic        hdr_empty
);
  typedef enum logic [1:0] {IDLE, REC, PUSH} state_t;
  state_t state, state_nxt;

  logic [20:0] dly     [32];
  logic [21:0] mem     [4096];
  logic [79:0] hdr_mem [512];

  logic [5:0]  fill_cnt;
  logic [11:0] wr_ptr, rd_ptr, start_addr, stop_addr;
  logic [11:0] word_cnt, last_idx, post_l, post_cnt;
  logic [47:0] evt_ltc;
  logic [1:0]  src_l;
  logic        cnst_l, fixed_len, arm_seen;
  logic [4:0]  pre_l;
  logic [8:0]  hdr_wr_ptr, hdr_rd_ptr;
  logic [9:0]  hdr_cnt;

  logic [20:0] tap;
  logic [11:0] min_len, conf_len, fix_len;
  logic        filled, accept, eoe, wr_en, abort, push_ok, mem_full, rd_ok, hdr_rd_ok;

  assign tap       = dly[pre_l];
  assign filled    = fill_cnt >= {1'b0, pre_conf};
  assign armed     = filled && (state == IDLE) && !wvb_overflow && (!trig_mode || arm_seen);
  assign accept    = trig && armed;
  assign wvb_wused = wr_ptr - rd_ptr;
  assign rd_ok     = wvb_rdreq && (wvb_wused != 12'd0);
  assign mem_full  = (wvb_wused == 12'hFFF) && !rd_ok;
  assign hdr_full  = hdr_cnt == 10'd512;
  assign hdr_empty = hdr_cnt == 10'd0;
  assign hdr_rd_ok = hdr_rdreq && !hdr_empty;

  assign min_len  = {7'd0, pre_conf} + 12'd1;
  assign conf_len = (trig_src == 2'd3) ? test_conf : cnst_conf;
  assign fix_len  = (conf_len > min_len) ? conf_len : min_len;

  // Tot-driven waveforms end once post_l consecutive low-tot samples follow the trigger.
  assign eoe = fixed_len ? (word_cnt == last_idx)
             : (word_cnt >= {7'd0, pre_l}) && !tap[0] &&
               (({1'b0, post_cnt} + 13'd1) >= {1'b0, post_l});

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    abort     = 1'b0;
    push_ok   = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = REC;
      REC: begin
        if (mem_full) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else begin
          wr_en = 1'b1;
          if (eoe) state_nxt = PUSH;
        end
      end
      PUSH: begin
        state_nxt = IDLE;
        if (hdr_full) abort = 1'b1;
        else          push_ok = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: storage arrays carry no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    dly[0] <= {discr_in, adc_in, tot};
    for (int i = 1; i < 32; i++) dly[i] <= dly[i-1];
    if (wr_en)   mem[wr_ptr] <= {tap, eoe};
    if (push_ok) hdr_mem[hdr_wr_ptr] <= {evt_ltc, start_addr, stop_addr, src_l, cnst_l, pre_l};
  end

  // NOTE: all state registers use non-blocking assignments so every edge sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      fill_cnt     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      start_addr   <= '0;
      stop_addr    <= '0;
      word_cnt     <= '0;
      last_idx     <= '0;
      post_l       <= '0;
      post_cnt     <= '0;
      evt_ltc      <= '0;
      src_l        <= '0;
      cnst_l       <= 1'b0;
      fixed_len    <= 1'b0;
      pre_l        <= '0;
      arm_seen     <= 1'b0;
      wvb_overflow <= 1'b0;
      wvb_data_out <= '0;
      n_wvf_in_buf <= '0;
      hdr_wr_ptr   <= '0;
      hdr_rd_ptr   <= '0;
      hdr_cnt      <= '0;
      hdr_data_out <= '0;
    end else begin
      state <= state_nxt;
      if (fill_cnt != 6'd32) fill_cnt <= fill_cnt + 6'd1;

      if (accept) begin
        evt_ltc    <= ltc_in;
        src_l      <= trig_src;
        cnst_l     <= cnst_run;
        pre_l      <= pre_conf;
        fixed_len  <= (trig_src == 2'd3) || cnst_run;
        last_idx   <= fix_len - 12'd1;
        post_l     <= post_conf;
        start_addr <= wr_ptr;
        word_cnt   <= '0;
        post_cnt   <= '0;
      end

      if (accept)   arm_seen <= 1'b0;
      else if (arm) arm_seen <= 1'b1;

      if (wr_en) begin
        wr_ptr   <= wr_ptr + 12'd1;
        word_cnt <= word_cnt + 12'd1;
        if (word_cnt >= {7'd0, pre_l}) post_cnt <= tap[0] ? 12'd0 : post_cnt + 12'd1;
        if (eoe) stop_addr <= wr_ptr;
      end

      if (abort) begin
        wvb_overflow <= 1'b1;
        wr_ptr       <= start_addr;
      end

      if (rd_ok) begin
        rd_ptr       <= rd_ptr + 12'd1;
        wvb_data_out <= mem[rd_ptr];
      end

      if (push_ok) hdr_wr_ptr <= hdr_wr_ptr + 9'd1;
      if (hdr_rd_ok) begin
        hdr_rd_ptr   <= hdr_rd_ptr + 9'd1;
        hdr_data_out <= hdr_mem[hdr_rd_ptr];
      end
      if (push_ok && !hdr_rd_ok)      hdr_cnt <= hdr_cnt + 10'd1;
      else if (!push_ok && hdr_rd_ok) hdr_cnt <= hdr_cnt - 10'd1;

      if (push_ok && !wvb_rddone)
        n_wvf_in_buf <= n_wvf_in_buf + 10'd1;
      else if (!push_ok && wvb_rddone && (n_wvf_in_buf != 10'd0))
        n_wvf_in_buf <= n_wvf_in_buf - 10'd1;
    end
  end
endmodule

// File: tb/tb_mdom_waveform_buffer.sv
// Directed bench for mdom_waveform_buffer: test, tot and constant-length
// waveforms, armed triggering, memory and header-FIFO overflow, reset recovery.
`timescale 1ns/1ps
module tb_mdom_waveform_buffer;
  logic        clk = 1'b0, rst = 1'b0;
  logic [47:0] ltc_in;
  logic [11:0] adc_in;
  logic [7:0]  discr_in;
  logic        tot, trig, arm, wvb_rdreq, hdr_rdreq, wvb_rddone, cnst_run, trig_mode;
  logic [1:0]  trig_src;
  logic [4:0]  pre_conf;
  logic [11:0] post_conf, test_conf, cnst_conf;
  logic [21:0] wvb_data_out;
  logic [11:0] wvb_wused;
  logic [9:0]  n_wvf_in_buf;
  logic        wvb_overflow, armed, hdr_full, hdr_empty;
  logic [79:0] hdr_data_out;

  int n_tests = 0, n_fail = 0;

  mdom_waveform_buffer dut (
    .clk(clk), .rst(rst), .ltc_in(ltc_in), .adc_in(adc_in), .discr_in(discr_in),
    .tot(tot), .trig(trig), .trig_src(trig_src), .arm(arm),
    .wvb_rdreq(wvb_rdreq), .hdr_rdreq(hdr_rdreq), .wvb_rddone(wvb_rddone),
    .pre_conf(pre_conf), .post_conf(post_conf), .test_conf(test_conf),
    .cnst_run(cnst_run), .cnst_conf(cnst_conf), .trig_mode(trig_mode),
    .wvb_data_out(wvb_data_out), .wvb_wused(wvb_wused), .n_wvf_in_buf(n_wvf_in_buf),
    .wvb_overflow(wvb_overflow), .armed(armed), .hdr_data_out(hdr_data_out),
    .hdr_full(hdr_full), .hdr_empty(hdr_empty)
  );

  initial forever #5 clk = ~clk;

  // Local time counter doubles as the ADC ramp; it restarts from 0 under reset.
  initial begin
    ltc_in = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst) ltc_in = '0;
      else      ltc_in = ltc_in + 48'd1;
    end
  end
  assign adc_in   = ltc_in[11:0];
  assign discr_in = ~ltc_in[7:0];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [21:0] exp_word(input logic [47:0] s, input logic t, input logic e);
    return {~s[7:0], s[11:0], t, e};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_trig(input logic [1:0] src, output logic [47:0] t);
    trig = 1'b1; trig_src = src; t = ltc_in;
    @(negedge clk);
    trig = 1'b0;
  endtask

  task automatic pop_hdr(output logic [79:0] h);
    hdr_rdreq = 1'b1;
    @(negedge clk);
    hdr_rdreq = 1'b0;
    h = hdr_data_out;
  endtask

  task automatic pulse_done();
    wvb_rddone = 1'b1;
    @(negedge clk);
    wvb_rddone = 1'b0;
  endtask

  task automatic wait_hdr();
    for (int i = 0; i < 200 && hdr_empty; i++) @(negedge clk);
  endtask

  task automatic wait_ltc(input logic [47:0] v);
    for (int i = 0; i < 6000 && ltc_in < v; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    tot = 0; trig = 0; arm = 0; wvb_rdreq = 0; hdr_rdreq = 0; wvb_rddone = 0;
    trig_src = 0; pre_conf = 5'd4; post_conf = 12'd4; test_conf = 12'd10;
    cnst_run = 0; cnst_conf = 12'd6; trig_mode = 0;
    rst = 1'b0;
    cyc(3);
    rst = 1'b1;
    n_tests++;
    if ({wvb_wused, n_wvf_in_buf, wvb_overflow, armed, hdr_full, hdr_empty} !== {12'd0, 10'd0, 4'b0001}) begin
      n_fail++;
      $display("FAIL reset_status: got %0h/%0h/%b%b%b%b want 0/0/0001",
               wvb_wused, n_wvf_in_buf, wvb_overflow, armed, hdr_full, hdr_empty);
    end
    n_tests++;
    if (wvb_data_out !== 22'd0 || hdr_data_out !== 80'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %0h/%0h want 0/0", wvb_data_out, hdr_data_out);
    end
    cyc(6);
    n_tests++;
    if (armed !== 1'b1) begin n_fail++; $display("FAIL armed_after_fill: got %b want 1", armed); end
  endtask

  task automatic test_test_trig();
    logic [47:0] t1, t2, s;
    logic [79:0] h1, h2;
    logic [11:0] d, nxt;
    logic [21:0] e;
    wait_ltc(48'd45);
    pulse_trig(2'd3, t1);
    wait_hdr();
    pop_hdr(h1);
    n_tests++;
    if (h1[79:32] !== 48'd45) begin n_fail++; $display("FAIL t1_evt_ltc: got %0d want 45", h1[79:32]); end
    d = h1[19:8] - h1[31:20];
    n_tests++;
    if (d !== 12'd9) begin n_fail++; $display("FAIL t1_len: got %0d want 9", d); end
    n_tests++;
    if (h1[7:0] !== {2'd3, 1'b0, 5'd4}) begin n_fail++; $display("FAIL t1_tags: got %0h want %0h", h1[7:0], {2'd3, 1'b0, 5'd4}); end
    n_tests++;
    if (n_wvf_in_buf !== 10'd1) begin n_fail++; $display("FAIL t1_nwvf: got %0d want 1", n_wvf_in_buf); end

    wait_ltc(48'd59);
    n_tests++;
    if (armed !== 1'b1) begin n_fail++; $display("FAIL t2_armed: got %b want 1", armed); end
    pulse_trig(2'd3, t2);
    wait_hdr();
    pop_hdr(h2);
    nxt = h1[19:8] + 12'd1;
    n_tests++;
    if (h2[79:32] !== 48'd59 || h2[31:20] !== nxt) begin
      n_fail++;
      $display("FAIL t2_hdr: got evt %0d start %0d want evt 59 start %0d", h2[79:32], h2[31:20], nxt);
    end
    n_tests++;
    if (n_wvf_in_buf !== 10'd2 || wvb_wused !== 12'd20) begin
      n_fail++;
      $display("FAIL t2_counts: got %0d/%0d want 2/20", n_wvf_in_buf, wvb_wused);
    end

    wvb_rdreq = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      s = ((k < 10) ? t1 : t2) - 48'd4 + 48'(k % 10);
      e = exp_word(s, 1'b0, (k % 10) == 9);
      n_tests++;
      if (wvb_data_out !== e) begin n_fail++; $display("FAIL t_word%0d: got %0h want %0h", k, wvb_data_out, e); end
    end
    wvb_rdreq = 1'b0;
    n_tests++;
    if (wvb_wused !== 12'd0) begin n_fail++; $display("FAIL t_drained: got %0d want 0", wvb_wused); end
    pulse_done();
    n_tests++;
    if (n_wvf_in_buf !== 10'd1) begin n_fail++; $display("FAIL rddone1: got %0d want 1", n_wvf_in_buf); end
    pulse_done();
    pulse_done();
    n_tests++;
    if (n_wvf_in_buf !== 10'd0) begin n_fail++; $display("FAIL rddone_floor: got %0d want 0", n_wvf_in_buf); end
  endtask

  task automatic run_tot(input logic [15:0] pat, input int exp_len);
    logic [47:0] t, s;
    logic [79:0] h;
    logic [11:0] d;
    logic [21:0] e;
    logic tb;
    cyc(2);
    trig = 1'b1; trig_src = 2'd1; tot = pat[0]; t = ltc_in;
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      trig = 1'b0;
      tot = pat[i];
    end
    @(negedge clk);
    tot = 1'b0;
    wait_hdr();
    pop_hdr(h);
    d = h[19:8] - h[31:20];
    n_tests++;
    if (d !== 12'(exp_len - 1)) begin n_fail++; $display("FAIL tot_len: got %0d want %0d", d, exp_len - 1); end
    wvb_rdreq = 1'b1;
    for (int k = 0; k < exp_len; k++) begin
      @(negedge clk);
      s  = t - 48'd4 + 48'(k);
      tb = (k >= 4) ? pat[k-4] : 1'b0;
      e  = exp_word(s, tb, k == exp_len - 1);
      n_tests++;
      if (wvb_data_out !== e) begin n_fail++; $display("FAIL tot_word%0d: got %0h want %0h", k, wvb_data_out, e); end
    end
    wvb_rdreq = 1'b0;
    pulse_done();
  endtask

  task automatic test_tot();
    run_tot(16'h0007, 11);
    run_tot(16'h0027, 14);
  endtask

  task automatic run_cnst(input logic [1:0] src, input logic [11:0] conf, input int exp_len);
    logic [47:0] t;
    logic [79:0] h;
    logic [11:0] d;
    logic [21:0] e;
    cyc(2);
    cnst_run = 1'b1; cnst_conf = conf;
    pulse_trig(src, t);
    wait_hdr();
    pop_hdr(h);
    d = h[19:8] - h[31:20];
    n_tests++;
    if (d !== 12'(exp_len - 1) || h[5] !== 1'b1 || h[7:6] !== src) begin
      n_fail++;
      $display("FAIL cnst_hdr: got len-1 %0d cnst %b src %0d want %0d 1 %0d", d, h[5], h[7:6], exp_len - 1, src);
    end
    wvb_rdreq = 1'b1;
    repeat (exp_len) @(negedge clk);
    wvb_rdreq = 1'b0;
    e = exp_word(t - 48'd4 + 48'(exp_len - 1), 1'b0, 1'b1);
    n_tests++;
    if (wvb_data_out !== e) begin n_fail++; $display("FAIL cnst_last: got %0h want %0h", wvb_data_out, e); end
    pulse_done();
    cnst_run = 1'b0;
  endtask

  task automatic test_cnst();
    run_cnst(2'd1, 12'd6, 6);
    run_cnst(2'd1, 12'd2, 5);
    test_conf = 12'd7;
    run_cnst(2'd3, 12'd6, 7);
    test_conf = 12'd10;
  endtask

  task automatic test_arm();
    logic [47:0] t;
    logic [79:0] h;
    trig_mode = 1'b1;
    cyc(2);
    n_tests++;
    if (armed !== 1'b0) begin n_fail++; $display("FAIL arm_idle: got %b want 0", armed); end
    pulse_trig(2'd3, t);
    cyc(15);
    n_tests++;
    if (hdr_empty !== 1'b1 || wvb_wused !== 12'd0) begin
      n_fail++;
      $display("FAIL arm_ignored: got empty %b wused %0d want 1/0", hdr_empty, wvb_wused);
    end
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    n_tests++;
    if (armed !== 1'b1) begin n_fail++; $display("FAIL arm_set: got %b want 1", armed); end
    pulse_trig(2'd3, t);
    n_tests++;
    if (armed !== 1'b0) begin n_fail++; $display("FAIL arm_drop: got %b want 0", armed); end
    wait_hdr();
    pop_hdr(h);
    n_tests++;
    if (h[79:32] !== t) begin n_fail++; $display("FAIL arm_evt: got %0d want %0d", h[79:32], t); end
    n_tests++;
    if (armed !== 1'b0) begin n_fail++; $display("FAIL arm_consumed: got %b want 0", armed); end
    wvb_rdreq = 1'b1;
    repeat (10) @(negedge clk);
    wvb_rdreq = 1'b0;
    pulse_done();
    trig_mode = 1'b0;
  endtask

  task automatic test_mem_overflow();
    logic [47:0] t;
    logic [79:0] h;
    logic [21:0] e;
    int bad;
    rst = 1'b0;
    cyc(2);
    rst = 1'b1;
    test_conf = 12'd4094;
    wait_ltc(48'd45);
    pulse_trig(2'd3, t);
    wait_ltc(48'd4141);
    n_tests++;
    if (armed !== 1'b1) begin n_fail++; $display("FAIL ovf_rearm: got %b want 1", armed); end
    pulse_trig(2'd3, t);
    cyc(10);
    n_tests++;
    if ({wvb_overflow, armed} !== 2'b10 || n_wvf_in_buf !== 10'd1 || wvb_wused !== 12'd4094) begin
      n_fail++;
      $display("FAIL ovf_state: got ovf %b armed %b nwvf %0d wused %0d want 1 0 1 4094",
               wvb_overflow, armed, n_wvf_in_buf, wvb_wused);
    end
    pulse_trig(2'd3, t);
    cyc(5);
    n_tests++;
    if (wvb_wused !== 12'd4094) begin n_fail++; $display("FAIL ovf_locked: got %0d want 4094", wvb_wused); end
    pop_hdr(h);
    n_tests++;
    if (h[79:8] !== {48'd45, 12'd0, 12'd4093} || hdr_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_hdr: got %0h empty %b want %0h empty 1", h[79:8], hdr_empty, {48'd45, 12'd0, 12'd4093});
    end
    bad = 0;
    wvb_rdreq = 1'b1;
    for (int k = 0; k < 4094; k++) begin
      @(negedge clk);
      e = exp_word(48'd41 + 48'(k), 1'b0, k == 4093);
      if (wvb_data_out !== e) begin
        if (bad == 0) $display("FAIL ovf_word%0d: got %0h want %0h", k, wvb_data_out, e);
        bad++;
      end
    end
    wvb_rdreq = 1'b0;
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL ovf_intact: got %0d bad words want 0", bad); end
    test_conf = 12'd10;
  endtask

  task automatic test_hdr_overflow();
    logic [47:0] t;
    logic [79:0] h;
    int cnt;
    rst = 1'b0;
    cyc(2);
    rst = 1'b1;
    test_conf = 12'd5;
    for (int i = 0; i < 600 && !wvb_overflow; i++) begin
      for (int j = 0; j < 20 && !armed; j++) @(negedge clk);
      if (armed) pulse_trig(2'd3, t);
    end
    cyc(10);
    n_tests++;
    if ({wvb_overflow, hdr_full, armed} !== 3'b110 || n_wvf_in_buf !== 10'd512 || wvb_wused !== 12'd2560) begin
      n_fail++;
      $display("FAIL hfull_state: got ovf %b full %b armed %b nwvf %0d wused %0d want 1 1 0 512 2560",
               wvb_overflow, hdr_full, armed, n_wvf_in_buf, wvb_wused);
    end
    cnt = 0;
    for (int i = 0; i < 600 && !hdr_empty; i++) begin
      pop_hdr(h);
      cnt++;
    end
    n_tests++;
    if (cnt != 512) begin n_fail++; $display("FAIL hfull_count: got %0d want 512", cnt); end
    n_tests++;
    if (h[31:8] !== {12'd2555, 12'd2559}) begin n_fail++; $display("FAIL hfull_last: got %0h want %0h", h[31:8], {12'd2555, 12'd2559}); end

    rst = 1'b0;
    cyc(2);
    rst = 1'b1;
    n_tests++;
    if ({wvb_overflow, hdr_empty} !== 2'b01 || n_wvf_in_buf !== 10'd0 || wvb_wused !== 12'd0) begin
      n_fail++;
      $display("FAIL recover_reset: got ovf %b empty %b nwvf %0d wused %0d want 0 1 0 0",
               wvb_overflow, hdr_empty, n_wvf_in_buf, wvb_wused);
    end
    test_conf = 12'd10;
    cyc(6);
    pulse_trig(2'd3, t);
    wait_hdr();
    pop_hdr(h);
    n_tests++;
    if (h[31:8] !== {12'd0, 12'd9} || n_wvf_in_buf !== 10'd1) begin
      n_fail++;
      $display("FAIL recover_wvf: got %0h nwvf %0d want 9 1", h[31:8], n_wvf_in_buf);
    end

    test_conf = 12'd100;
    cyc(2);
    pulse_trig(2'd3, t);
    cyc(20);
    rst = 1'b0;
    #1;
    n_tests++;
    if (hdr_empty !== 1'b1 || wvb_wused !== 12'd0 || n_wvf_in_buf !== 10'd0) begin
      n_fail++;
      $display("FAIL abort_reset: got empty %b wused %0d nwvf %0d want 1 0 0", hdr_empty, wvb_wused, n_wvf_in_buf);
    end
    @(negedge clk);
    rst = 1'b1;
    test_conf = 12'd10;
  endtask

  initial begin
    test_reset();
    test_test_trig();
    test_tot();
    test_cnst();
    test_arm();
    test_mem_overflow();
    test_hdr_overflow();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
